// File: rtl/foc_pkg.sv
// Shared types and constants for the FOC current-loop front end.
// Used by the sequencer, Park and PI stages.
package foc_pkg;

    localparam int FOC_D_WIDTH = 18;
    localparam int FOC_Q_BITS  = 15;

    // Signed D/Q sample, FOC_Q_BITS fractional bits.
    typedef logic signed [FOC_D_WIDTH-1:0] dq_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LAUNCH   = 3'd1,
        WAIT_IN  = 3'd2,
        PARK_RUN = 3'd3,
        CAPTURE  = 3'd4
    } foc_seq_state_t;

    // Bits needed for a counter that must be able to hold max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that saturates at all-ones; clear has priority over increment.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;

    // NOTE: registered state is written only with non-blocking assignments so
    // every flop samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/foc_park_sequencer.sv
// Per-PWM-period sequencer: Clarke + CORDIC in parallel, then Park, then D/Q capture.
// Define FOC_SEQ_TIMEOUT_EN to build the input-stage stall timeout.
module foc_park_sequencer
    import foc_pkg::*;
#(
    parameter int D_WIDTH     = FOC_D_WIDTH,
    parameter int PARK_LAT    = 2,
    parameter int TIMEOUT_CYC = 64,
    parameter int OVR_WIDTH   = 8
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      trig,
    output logic                      clarke_start,
    input  logic                      clarke_done,
    output logic                      cordic_start,
    input  logic                      cordic_done,
    output logic                      park_start,
    input  logic signed [D_WIDTH-1:0] park_d,
    input  logic signed [D_WIDTH-1:0] park_q,
    output logic signed [D_WIDTH-1:0] d_out,
    output logic signed [D_WIDTH-1:0] q_out,
    output logic                      dq_valid,
    output logic                      busy,
    output logic                      timeout_err,
    input  logic                      err_clr,
    output logic [OVR_WIDTH-1:0]      ovr_cnt
);

    localparam int PARK_W = cnt_width(PARK_LAT - 1);

    foc_seq_state_t            state_q;
    logic                      cl_ok_q;
    logic                      co_ok_q;
    logic                      clarke_start_q;
    logic                      cordic_start_q;
    logic                      dq_valid_q;
    logic                      busy_q;
    logic [PARK_W-1:0]         park_cnt_q;
    logic signed [D_WIDTH-1:0] d_out_q;
    logic signed [D_WIDTH-1:0] q_out_q;

    logic in_wait;
    logic cl_seen;
    logic co_seen;
    logic both_seen;
    logic park_go;
    logic timeout_hit;

    // A done arriving this very cycle counts, so park_start need not wait a cycle.
    assign in_wait   = (state_q == WAIT_IN);
    assign cl_seen   = cl_ok_q | clarke_done;
    assign co_seen   = co_ok_q | cordic_done;
    assign both_seen = cl_seen & co_seen;
    assign park_go   = in_wait & both_seen;

`ifdef FOC_SEQ_TIMEOUT_EN
    localparam int WAIT_W = cnt_width(TIMEOUT_CYC - 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_err_q;

    sat_counter #(
        .WIDTH (WAIT_W)
    ) u_wait_cnt (
        .clk   (clk),
        .rstb  (rstb),
        .inc_i (in_wait),
        .clr_i (state_q == LAUNCH),
        .cnt_o (wait_cnt)
    );

    // Fires on the TIMEOUT_CYC-th WAIT_IN cycle still missing a done.
    assign timeout_hit = in_wait & ~both_seen & (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1));

    // A new stall outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            timeout_err_q <= 1'b0;
        end else if (timeout_hit) begin
            timeout_err_q <= 1'b1;
        end else if (err_clr) begin
            timeout_err_q <= 1'b0;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    sat_counter #(
        .WIDTH (OVR_WIDTH)
    ) u_ovr_cnt (
        .clk   (clk),
        .rstb  (rstb),
        .inc_i (trig & busy_q),
        .clr_i (err_clr),
        .cnt_o (ovr_cnt)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q        <= IDLE;
            cl_ok_q        <= 1'b0;
            co_ok_q        <= 1'b0;
            clarke_start_q <= 1'b0;
            cordic_start_q <= 1'b0;
            dq_valid_q     <= 1'b0;
            busy_q         <= 1'b0;
            park_cnt_q     <= '0;
            d_out_q        <= '0;
            q_out_q        <= '0;
        end else begin
            clarke_start_q <= 1'b0;
            cordic_start_q <= 1'b0;
            dq_valid_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (trig) begin
                        state_q        <= LAUNCH;
                        clarke_start_q <= 1'b1;
                        cordic_start_q <= 1'b1;
                        busy_q         <= 1'b1;
                    end
                end
                LAUNCH: begin
                    cl_ok_q <= clarke_done;
                    co_ok_q <= cordic_done;
                    state_q <= WAIT_IN;
                end
                WAIT_IN: begin
                    cl_ok_q <= cl_seen;
                    co_ok_q <= co_seen;
                    if (park_go) begin
                        state_q    <= PARK_RUN;
                        park_cnt_q <= '0;
                    end else if (timeout_hit) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                PARK_RUN: begin
                    // Park outputs are stable by now; capturing on entry lets
                    // d_out/q_out already hold the new sample while dq_valid is high.
                    if (park_cnt_q == PARK_W'(PARK_LAT - 1)) begin
                        state_q    <= CAPTURE;
                        d_out_q    <= park_d;
                        q_out_q    <= park_q;
                        dq_valid_q <= 1'b1;
                    end else begin
                        park_cnt_q <= park_cnt_q + PARK_W'(1);
                    end
                end
                CAPTURE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign clarke_start = clarke_start_q;
    assign cordic_start = cordic_start_q;
    assign park_start   = park_go;
    assign dq_valid     = dq_valid_q;
    assign busy         = busy_q;
    assign d_out        = d_out_q;
    assign q_out        = q_out_q;

endmodule

// File: tb/tb_foc_park_sequencer.sv
// Directed bench for foc_park_sequencer with a D/Q scoreboard.
// Also covers the FOC_SEQ_TIMEOUT_EN build when that macro is defined.
module tb_foc_park_sequencer;
    import foc_pkg::*;

    logic       clk = 1'b0;
    logic       rstb;
    logic       trig;
    logic       clarke_start;
    logic       clarke_done;
    logic       cordic_start;
    logic       cordic_done;
    logic       park_start;
    dq_t        park_d;
    dq_t        park_q;
    dq_t        d_out;
    dq_t        q_out;
    logic       dq_valid;
    logic       busy;
    logic       timeout_err;
    logic       err_clr;
    logic [7:0] ovr_cnt;

    typedef struct packed {
        dq_t d;
        dq_t q;
    } dq_pair_t;

    dq_pair_t exp_q[$];
    int       total   = 0;
    int       bad     = 0;
    int       exp_ovr = 0;
    dq_t      last_d  = '0;

    foc_park_sequencer dut (
        .clk          (clk),
        .rstb         (rstb),
        .trig         (trig),
        .clarke_start (clarke_start),
        .clarke_done  (clarke_done),
        .cordic_start (cordic_start),
        .cordic_done  (cordic_done),
        .park_start   (park_start),
        .park_d       (park_d),
        .park_q       (park_q),
        .d_out        (d_out),
        .q_out        (q_out),
        .dq_valid     (dq_valid),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .err_clr      (err_clr),
        .ovr_cnt      (ovr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every dq_valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (dq_valid === 1'b1) begin
            check("dq_valid_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                dq_pair_t e;
                e = exp_q.pop_front();
                check("d_out", 32'(d_out), 32'(e.d));
                check("q_out", 32'(q_out), 32'(e.q));
            end
        end
    end

    // Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        trig        = 1'b0;
        clarke_done = 1'b0;
        cordic_done = 1'b0;
        err_clr     = 1'b0;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // One full transaction; k counts cycles from the accepted trigger (k=0).
    // Extra triggers in [trig_from, trig_to] land while busy; clr_at pulses err_clr.
    task automatic run_txn(input int cl_dly, input int co_dly, input int trig_from,
                           input int trig_to, input int clr_at, input dq_t d, input dq_t q);
        int exp_ps;
        int last;
        int n_ps;
        int ps_at;
        int dv_at;
        exp_ps = (cl_dly > co_dly) ? cl_dly : co_dly;
        if (exp_ps < 2) exp_ps = 2;
        last  = exp_ps + 3;
        n_ps  = 0;
        ps_at = -1;
        dv_at = -1;
        exp_q.push_back('{d: d, q: q});
        last_d = d;
        for (int k = 0; k <= last; k++) begin
            cyc();
            park_d      = d;
            park_q      = q;
            trig        = (k == 0) || (k >= trig_from && k <= trig_to);
            clarke_done = (k == cl_dly);
            cordic_done = (k == co_dly);
            err_clr     = (k == clr_at);
            if (err_clr) exp_ovr = 0;
            else if (trig && k >= 1 && exp_ovr != 255) exp_ovr++;
            smp();
            if (k == 0) check("idle_on_trig", 32'(busy), 32'd0);
            if (k == 1) check("launch_pulses", 32'({clarke_start, cordic_start, busy}), 32'b111);
            if (k == 2) check("launch_once", 32'({clarke_start, cordic_start}), 32'b00);
            if (park_start === 1'b1) begin
                n_ps++;
                ps_at = k;
            end
            if (dq_valid === 1'b1) dv_at = k;
        end
        check("park_start_count", 32'(n_ps), 32'd1);
        check("park_start_cycle", 32'(ps_at), 32'(exp_ps));
        check("dq_valid_cycle", 32'(dv_at), 32'(exp_ps + 3));
        cyc();
        smp();
        check("idle_after_txn", 32'({busy, dq_valid, park_start}), 32'b000);
        check("ovr_cnt", 32'(ovr_cnt), 32'(exp_ovr));
    endtask

`ifdef FOC_SEQ_TIMEOUT_EN
    // Only clarke_done arrives; the 64th WAIT_IN cycle (k=65) must abort to IDLE.
    task automatic timeout_txn(input int clr_at);
        int n_ps;
        int idle_at;
        n_ps    = 0;
        idle_at = -1;
        for (int k = 0; k <= 70; k++) begin
            cyc();
            trig        = (k == 0);
            clarke_done = (k == 2);
            err_clr     = (k == clr_at);
            if (err_clr) exp_ovr = 0;
            smp();
            if (park_start === 1'b1) n_ps++;
            if (k == 65) begin
                check("to_still_busy", 32'(busy), 32'd1);
                if (clr_at < 0) check("to_not_yet", 32'(timeout_err), 32'd0);
            end
            if (k >= 1 && busy === 1'b0 && idle_at < 0) idle_at = k;
        end
        check("to_no_park_start", 32'(n_ps), 32'd0);
        check("to_idle_cycle", 32'(idle_at), 32'd66);
        check("to_err_set", 32'(timeout_err), 32'd1);
        check("to_d_hold", 32'(d_out), 32'(last_d));
    endtask
`endif

    initial begin
        int n_dv;
        rstb        = 1'b0;
        trig        = 1'b0;
        clarke_done = 1'b0;
        cordic_done = 1'b0;
        err_clr     = 1'b0;
        park_d      = '0;
        park_q      = '0;

        repeat (2) @(posedge clk);
        smp();
        check("rst_flags", 32'({clarke_start, cordic_start, park_start, dq_valid, busy, timeout_err}), 32'd0);
        check("rst_dq", 32'({d_out, q_out}), 32'd0);
        check("rst_ovr", 32'(ovr_cnt), 32'd0);
        @(posedge clk);
        #1 rstb = 1'b1;

        // Nominal: clarke 3 cycles, cordic 5 cycles after the trigger.
        run_txn(3, 5, -1, -1, -1, 18'sd1234, -18'sd567);
        check("d_out_hold", 32'(d_out), 32'(dq_t'(18'sd1234)));
        check("q_out_hold", 32'(q_out), 32'(dq_t'(-18'sd567)));

        // Both dones together, both in LAUNCH, and reversed order; full-scale values.
        run_txn(4, 4, -1, -1, -1, 18'sh1FFFF, 18'sh20000);
        run_txn(1, 1, -1, -1, -1, -18'sd1, 18'sd1);
        run_txn(6, 2, -1, -1, -1, 18'sd777, -18'sd9000);

        // 300 triggers while busy, 60 per transaction; the counter stops at 255.
        for (int t = 0; t < 5; t++) begin
            run_txn(60, 60, 1, 60, -1, dq_t'(100 + t), dq_t'(-200 - t));
        end

        // err_clr in the same cycle as an overrun wins.
        run_txn(3, 3, 2, 2, 2, 18'sd42, -18'sd42);
        // A trigger during CAPTURE is an overrun and does not restart.
        run_txn(3, 3, 6, 6, -1, 18'sd5, 18'sd6);

        // Stale cordic_done in IDLE must not satisfy the next wait.
        cyc();
        cordic_done = 1'b1;
        smp();
        cyc();
        smp();
        check("stray_idle", 32'(busy), 32'd0);
        run_txn(2, 40, -1, -1, -1, -18'sd3210, 18'sd123);
        check("no_timeout_err", 32'(timeout_err), 32'd0);

`ifdef FOC_SEQ_TIMEOUT_EN
        timeout_txn(-1);
        timeout_txn(65);
        cyc();
        err_clr = 1'b1;
        exp_ovr = 0;
        smp();
        cyc();
        smp();
        check("to_err_cleared", 32'(timeout_err), 32'd0);
        run_txn(3, 5, -1, -1, -1, 18'sd2468, -18'sd1357);
`endif

        // Reset while in PARK_RUN: everything clears, the pending result is dropped.
        for (int k = 0; k <= 3; k++) begin
            cyc();
            trig        = (k == 0);
            clarke_done = (k == 2);
            cordic_done = (k == 2);
            smp();
        end
        cyc();
        rstb    = 1'b0;
        exp_ovr = 0;
        #1;
        check("midrst_flags", 32'({clarke_start, cordic_start, park_start, dq_valid, busy, timeout_err}), 32'd0);
        check("midrst_d", 32'(d_out), 32'd0);
        check("midrst_q", 32'(q_out), 32'd0);
        @(posedge clk);
        #1 rstb = 1'b1;
        n_dv = 0;
        for (int k = 0; k < 8; k++) begin
            smp();
            if (dq_valid === 1'b1) n_dv++;
        end
        check("midrst_no_dq_valid", 32'(n_dv), 32'd0);
        check("midrst_idle", 32'(busy), 32'd0);
        run_txn(3, 5, -1, -1, -1, -18'sd1111, 18'sd2222);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
